// File: rtl/spi_dual_tx_arbiter.sv
// Round-robin arbiter sharing one SPI-style mode-0 serialiser between two word requesters.
// Each channel keeps its own CS/SCLK/SDO pins; only the granted channel leaves its idle levels.
module spi_dual_tx_arbiter #(
  parameter int DATA_W   = 16,
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int IDLE_GAP = 2
) (
  input  logic              CLK_IN,
  input  logic              RST_N,
  input  logic              REQ1,
  input  logic [DATA_W-1:0] DATA1,
  output logic              ACK1,
  input  logic              REQ2,
  input  logic [DATA_W-1:0] DATA2,
  output logic              ACK2,
  output logic              BUSY,
  output logic              CS1,
  output logic              SCLK1,
  output logic              SDO1,
  output logic              CS2,
  output logic              SCLK2,
  output logic              SDO2
);

  localparam int GAP_N  = (IDLE_GAP > 0) ? IDLE_GAP : 1;
  localparam int PH_MAX = (CS_SETUP > CS_HOLD) ? ((CS_SETUP > GAP_N) ? CS_SETUP : GAP_N)
                                               : ((CS_HOLD > GAP_N) ? CS_HOLD : GAP_N);
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int HALF_W = (DATA_W > 1) ? $clog2(2 * DATA_W) : 1;

  localparam logic [PH_W-1:0]   SETUP_LAST = PH_W'(CS_SETUP - 1);
  localparam logic [PH_W-1:0]   HOLD_LAST  = PH_W'(CS_HOLD - 1);
  localparam logic [PH_W-1:0]   GAP_LAST   = PH_W'(GAP_N - 1);
  localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [HALF_W-1:0] HALF_LAST  = HALF_W'(2 * DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } state_t;

  state_t              state_r;
  logic                gnt_r;         // 0: channel 1, 1: channel 2
  logic                last_grant_r;  // same encoding; resets to channel 2
  logic [DATA_W-1:0]   shreg_r;
  logic [DATA_W-1:0]   shifted_s;
  logic [PH_W-1:0]     ph_cnt_r;
  logic [DIV_W-1:0]    div_cnt_r;
  logic [HALF_W-1:0]   half_cnt_r;
  logic                pick_valid_s;
  logic                pick_s;

  assign shifted_s = shreg_r << 1;

  // Round-robin choice among the currently raised requests
  always_comb begin
    pick_valid_s = REQ1 | REQ2;
    if (REQ1 && REQ2) begin
      pick_s = ~last_grant_r;
    end else if (REQ2) begin
      pick_s = 1'b1;
    end else begin
      pick_s = 1'b0;
    end
  end

  // Frame sequencer; every pin is driven straight from this register set
  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      state_r      <= IDLE;
      gnt_r        <= 1'b0;
      last_grant_r <= 1'b1;
      shreg_r      <= '0;
      ph_cnt_r     <= '0;
      div_cnt_r    <= '0;
      half_cnt_r   <= '0;
      ACK1         <= 1'b0;
      ACK2         <= 1'b0;
      BUSY         <= 1'b0;
      CS1          <= 1'b1;
      SCLK1        <= 1'b0;
      SDO1         <= 1'b0;
      CS2          <= 1'b1;
      SCLK2        <= 1'b0;
      SDO2         <= 1'b0;
    end else begin
      ACK1 <= 1'b0;
      ACK2 <= 1'b0;
      case (state_r)
        IDLE: begin
          if (pick_valid_s) begin
            gnt_r        <= pick_s;
            last_grant_r <= pick_s;
            shreg_r      <= pick_s ? DATA2 : DATA1;
            ACK1         <= ~pick_s;
            ACK2         <= pick_s;
            BUSY         <= 1'b1;
            CS1          <= pick_s;
            CS2          <= ~pick_s;
            SDO1         <= ~pick_s & DATA1[DATA_W-1];
            SDO2         <= pick_s & DATA2[DATA_W-1];
            ph_cnt_r     <= '0;
            state_r      <= SETUP;
          end
        end
        SETUP: begin
          if (ph_cnt_r == SETUP_LAST) begin
            ph_cnt_r   <= '0;
            div_cnt_r  <= '0;
            half_cnt_r <= '0;
            state_r    <= SHIFT;
          end else begin
            ph_cnt_r <= ph_cnt_r + 1'b1;
          end
        end
        SHIFT: begin
          if (div_cnt_r == DIV_LAST) begin
            div_cnt_r <= '0;
            // even half-periods end on a rising edge, odd ones on a falling edge
            SCLK1 <= ~gnt_r & ~half_cnt_r[0];
            SCLK2 <= gnt_r & ~half_cnt_r[0];
            if (half_cnt_r == HALF_LAST) begin
              half_cnt_r <= '0;
              ph_cnt_r   <= '0;
              state_r    <= HOLD;
            end else begin
              half_cnt_r <= half_cnt_r + 1'b1;
              if (half_cnt_r[0]) begin
                shreg_r <= shifted_s;
                SDO1    <= ~gnt_r & shifted_s[DATA_W-1];
                SDO2    <= gnt_r & shifted_s[DATA_W-1];
              end
            end
          end else begin
            div_cnt_r <= div_cnt_r + 1'b1;
          end
        end
        HOLD: begin
          if (ph_cnt_r == HOLD_LAST) begin
            ph_cnt_r <= '0;
            CS1      <= 1'b1;
            CS2      <= 1'b1;
            SDO1     <= 1'b0;
            SDO2     <= 1'b0;
            if (IDLE_GAP == 0) begin
              BUSY    <= 1'b0;
              state_r <= IDLE;
            end else begin
              state_r <= GAP;
            end
          end else begin
            ph_cnt_r <= ph_cnt_r + 1'b1;
          end
        end
        GAP: begin
          if (ph_cnt_r == GAP_LAST) begin
            ph_cnt_r <= '0;
            BUSY     <= 1'b0;
            state_r  <= IDLE;
          end else begin
            ph_cnt_r <= ph_cnt_r + 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
          BUSY    <= 1'b0;
          CS1     <= 1'b1;
          SCLK1   <= 1'b0;
          SDO1    <= 1'b0;
          CS2     <= 1'b1;
          SCLK2   <= 1'b0;
          SDO2    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_dual_tx_arbiter.sv
// Directed + randomized bench for spi_dual_tx_arbiter: a pin-level monitor decodes every frame
// and compares it with grants predicted from the round-robin rules.
module tb_spi_dual_tx_arbiter;

  localparam int CS_LOW  = 2 + 2 * 16 * 4 + 2;
  localparam int SPACING = 1 + CS_LOW + 2;
  localparam int S_CS_LOW  = 1 + 2 * 8 * 1 + 1;
  localparam int S_SPACING = 1 + S_CS_LOW + 0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req1 = 1'b0, req2 = 1'b0;
  logic [15:0] data1 = 16'h0, data2 = 16'h0;
  logic        ack1, ack2, busy, cs1, sclk1, sdo1, cs2, sclk2, sdo2;

  logic        s_req1 = 1'b0, s_req2 = 1'b0;
  logic [7:0]  s_data1 = 8'h0, s_data2 = 8'h0;
  logic        s_ack1, s_ack2, s_busy, s_cs1, s_sclk1, s_sdo1, s_cs2, s_sclk2, s_sdo2;

  always #5 clk = ~clk;

  spi_dual_tx_arbiter dut (
    .CLK_IN(clk), .RST_N(rst_n),
    .REQ1(req1), .DATA1(data1), .ACK1(ack1),
    .REQ2(req2), .DATA2(data2), .ACK2(ack2),
    .BUSY(busy),
    .CS1(cs1), .SCLK1(sclk1), .SDO1(sdo1),
    .CS2(cs2), .SCLK2(sclk2), .SDO2(sdo2)
  );

  spi_dual_tx_arbiter #(.DATA_W(8), .CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(1), .IDLE_GAP(0)) dut_s (
    .CLK_IN(clk), .RST_N(rst_n),
    .REQ1(s_req1), .DATA1(s_data1), .ACK1(s_ack1),
    .REQ2(s_req2), .DATA2(s_data2), .ACK2(s_ack2),
    .BUSY(s_busy),
    .CS1(s_cs1), .SCLK1(s_sclk1), .SDO1(s_sdo1),
    .CS2(s_cs2), .SCLK2(s_sclk2), .SDO2(s_sdo2)
  );

  typedef struct { int ch; logic [15:0] word; int len; int rises; } frame_t;
  typedef struct { int ch; logic [15:0] word; } exp_t;

  int n_cmp = 0, n_err = 0;
  int cyc = 0;
  frame_t frames[$];
  frame_t s_frames[$];
  exp_t   exp_q[$];
  int     ack_ch[$], ack_cyc[$], s_ack_cyc[$];
  int     idle_viol = 0, s_viol = 0;
  int     last_model = 2;

  logic [1:0]  cs_b, sclk_b, sdo_b, prev_cs, prev_sclk;
  int          len_c[2], rises_c[2];
  logic [15:0] word_c[2];
  int          s_len, s_rises;
  logic [7:0]  s_word;
  logic        s_prev_cs, s_prev_sclk;

  assign cs_b   = {cs2, cs1};
  assign sclk_b = {sclk2, sclk1};
  assign sdo_b  = {sdo2, sdo1};

  always @(posedge clk) cyc <= cyc + 1;

  // Pin monitor for the default-parameter instance
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < 2; c++) begin
        len_c[c] = 0; rises_c[c] = 0; word_c[c] = 16'h0;
      end
      prev_cs = 2'b11; prev_sclk = 2'b00;
    end else begin
      if (ack1) begin ack_ch.push_back(1); ack_cyc.push_back(cyc); end
      if (ack2) begin ack_ch.push_back(2); ack_cyc.push_back(cyc); end
      if (!cs_b[0] && !cs_b[1]) idle_viol++;
      for (int c = 0; c < 2; c++) begin
        if (!cs_b[c]) begin
          len_c[c]++;
          if (sclk_b[c] && !prev_sclk[c]) begin
            word_c[c] = {word_c[c][14:0], sdo_b[c]};
            rises_c[c]++;
          end
        end else begin
          if (sclk_b[c] || sdo_b[c]) idle_viol++;
          if (!prev_cs[c]) begin
            frames.push_back('{c + 1, word_c[c], len_c[c], rises_c[c]});
            len_c[c] = 0; rises_c[c] = 0; word_c[c] = 16'h0;
          end
        end
      end
      prev_cs = cs_b; prev_sclk = sclk_b;
    end
  end

  // Pin monitor for the small-parameter instance (channel 1 only is used)
  always @(negedge clk) begin
    if (!rst_n) begin
      s_len = 0; s_rises = 0; s_word = 8'h0; s_prev_cs = 1'b1; s_prev_sclk = 1'b0;
    end else begin
      if (s_ack1) s_ack_cyc.push_back(cyc);
      if (!s_cs2 || s_sclk2 || s_sdo2 || s_ack2) s_viol++;
      if (!s_cs1) begin
        s_len++;
        if (s_sclk1 && !s_prev_sclk) begin s_word = {s_word[6:0], s_sdo1}; s_rises++; end
      end else begin
        if (s_sclk1 || s_sdo1) s_viol++;
        if (!s_prev_cs) begin
          s_frames.push_back('{1, {8'h0, s_word}, s_len, s_rises});
          s_len = 0; s_rises = 0; s_word = 8'h0;
        end
      end
      s_prev_cs = s_cs1; s_prev_sclk = s_sclk1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic int arb(input bit r1, input bit r2, input int last);
    if (r1 && r2) return (last == 1) ? 2 : 1;
    else if (r2) return 2;
    else return 1;
  endfunction

  task automatic wait_ack(input string tag, output int ch);
    int n;
    n = 0;
    do begin tick(); n++; end while (!(ack1 || ack2) && n < 400);
    check({tag, "_ack_seen"}, 32'(ack1 | ack2), 32'd1);
    ch = ack1 ? 1 : (ack2 ? 2 : 0);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    do begin tick(); n++; end while (busy && n < 700);
    check({tag, "_idle"}, 32'(busy), 32'd0);
    repeat (2) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req1 = 1'b0; req2 = 1'b0; s_req1 = 1'b0; s_req2 = 1'b0;
    repeat (3) tick();
    frames.delete(); exp_q.delete(); ack_ch.delete(); ack_cyc.delete();
    idle_viol = 0;
    last_model = 2;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic cmp_frames(input string tag);
    check({tag, "_frames"}, 32'(frames.size()), 32'(exp_q.size()));
    if (frames.size() == exp_q.size()) begin
      foreach (exp_q[i]) begin
        check({tag, "_ch"}, 32'(frames[i].ch), 32'(exp_q[i].ch));
        check({tag, "_word"}, 32'(frames[i].word), 32'(exp_q[i].word));
        check({tag, "_cslow"}, 32'(frames[i].len), 32'(CS_LOW));
        check({tag, "_rises"}, 32'(frames[i].rises), 32'd16);
      end
    end
    check({tag, "_idle_pins"}, 32'(idle_viol), 32'd0);
  endtask

  task automatic check_spacing(input string tag);
    for (int i = 1; i < ack_cyc.size(); i++)
      check({tag, "_spacing"}, 32'(ack_cyc[i] - ack_cyc[i-1]), 32'(SPACING));
  endtask

  initial begin
    int ch, pred, n, p;
    logic [15:0] w;
    bit pend1, pend2;

    // reset state
    #2 rst_n = 1'b0;
    #1;
    check("rst_pins", {23'h0, cs1, sclk1, sdo1, cs2, sclk2, sdo2, ack1, ack2, busy}, 32'h120);
    check("rst_pins_s", {23'h0, s_cs1, s_sclk1, s_sdo1, s_cs2, s_sclk2, s_sdo2, s_ack1, s_ack2, s_busy}, 32'h120);
    do_reset();

    // single ch1 frame A5C3, then a held request for a back-to-back random word
    data1 = 16'hA5C3; req1 = 1'b1;
    wait_ack("t1a", ch);
    check("t1a_ch", 32'(ch), 32'd1);
    exp_q.push_back('{1, 16'hA5C3});
    w = 16'($urandom); data1 = w;
    tick();
    check("t1_ack_width", 32'(ack1), 32'd0);
    check("t1_busy", 32'(busy), 32'd1);
    wait_ack("t1b", ch);
    req1 = 1'b0;
    check("t1b_ch", 32'(ch), 32'd1);
    exp_q.push_back('{1, w});
    wait_idle("t1");
    check_spacing("t1");
    cmp_frames("t1");

    // both requesters held: alternate grants
    do_reset();
    data1 = 16'h0001; data2 = 16'h8000; req1 = 1'b1; req2 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      pred = arb(1'b1, 1'b1, last_model);
      wait_ack("t2", ch);
      check("t2_order", 32'(ch), 32'(pred));
      exp_q.push_back('{ch, (ch == 1) ? data1 : data2});
      last_model = ch;
      if (ch == 1) data1 = 16'($urandom); else data2 = 16'($urandom);
    end
    req1 = 1'b0; req2 = 1'b0;
    wait_idle("t2");
    check_spacing("t2");
    cmp_frames("t2");

    // ch2 alone for three frames
    do_reset();
    data2 = 16'($urandom); req2 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_ack("t3", ch);
      check("t3_ch", 32'(ch), 32'd2);
      exp_q.push_back('{2, data2});
      data2 = 16'($urandom);
    end
    req2 = 1'b0;
    wait_idle("t3");
    check_spacing("t3");
    cmp_frames("t3");

    // reset pulse in the middle of a ch1 frame
    do_reset();
    data1 = 16'($urandom); req1 = 1'b1;
    wait_ack("t4", ch);
    req1 = 1'b0;
    repeat (49) tick();
    check("t4_cs1_mid", 32'(cs1), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t4_async_pins", {29'h0, cs1, sclk1, busy}, 32'h4);
    w = 16'($urandom); data1 = w; req1 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t4_no_ack_rst", {30'h0, ack1, ack2}, 32'h0);
    end
    frames.delete(); exp_q.delete(); ack_ch.delete(); ack_cyc.delete(); idle_viol = 0;
    rst_n = 1'b1;
    tick();
    check("t4_ack_after_rst", 32'(ack1), 32'd1);
    req1 = 1'b0;
    exp_q.push_back('{1, w});
    wait_idle("t4");
    cmp_frames("t4");

    // REQ1 pulse while ch2 frame is busy is ignored
    do_reset();
    data2 = 16'($urandom); req2 = 1'b1;
    wait_ack("t6", ch);
    req2 = 1'b0;
    exp_q.push_back('{2, data2});
    repeat (20) tick();
    data1 = 16'hFFFF; req1 = 1'b1;
    tick();
    req1 = 1'b0;
    wait_idle("t6");
    repeat (5) tick();
    check("t6_acks", 32'(ack_ch.size()), 32'd1);
    cmp_frames("t6");

    // randomized request patterns against the round-robin model
    do_reset();
    pend1 = 1'b0; pend2 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (!pend1 && !pend2) begin
        p = $urandom_range(1, 3);
        pend1 = p[0]; pend2 = p[1];
        if (pend1) data1 = 16'($urandom);
        if (pend2) data2 = 16'($urandom);
      end else if ($urandom_range(0, 1) == 1) begin
        if (!pend1) data1 = 16'($urandom);
        if (!pend2) data2 = 16'($urandom);
        pend1 = 1'b1; pend2 = 1'b1;
      end
      req1 = pend1; req2 = pend2;
      pred = arb(pend1, pend2, last_model);
      wait_ack("t7", ch);
      check("t7_grant", 32'(ch), 32'(pred));
      exp_q.push_back('{ch, (ch == 1) ? data1 : data2});
      last_model = ch;
      if (ch == 1) pend1 = 1'b0; else pend2 = 1'b0;
      req1 = pend1; req2 = pend2;
    end
    req1 = 1'b0; req2 = 1'b0;
    wait_idle("t7");
    cmp_frames("t7");

    // small parameter set: 8-bit, CLK_DIV=1, no gap
    s_data1 = 8'h5A; s_req1 = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!s_ack1 && n < 100);
    check("t5a_ack_seen", 32'(s_ack1), 32'd1);
    s_data1 = 8'($urandom); w = {8'h0, s_data1};
    n = 0;
    do begin tick(); n++; end while (!s_ack1 && n < 100);
    check("t5b_ack_seen", 32'(s_ack1), 32'd1);
    s_req1 = 1'b0;
    n = 0;
    do begin tick(); n++; end while (s_busy && n < 100);
    check("t5_idle", 32'(s_busy), 32'd0);
    repeat (2) tick();
    check("t5_frames", 32'(s_frames.size()), 32'd2);
    if (s_frames.size() == 2) begin
      check("t5_word0", 32'(s_frames[0].word), 32'h5A);
      check("t5_word1", 32'(s_frames[1].word), 32'(w));
      check("t5_cslow", 32'(s_frames[0].len), 32'(S_CS_LOW));
      check("t5_rises", 32'(s_frames[0].rises), 32'd8);
    end
    check("t5_acks", 32'(s_ack_cyc.size()), 32'd2);
    if (s_ack_cyc.size() == 2)
      check("t5_spacing", 32'(s_ack_cyc[1] - s_ack_cyc[0]), 32'(S_SPACING));
    check("t5_idle_pins", 32'(s_viol), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spi_dual_tx_arbiter.md
Name: spi_dual_tx_arbiter

Overview:
- Shares one SPI-style serialiser between two word-level requesters, replacing the two free-running per-channel generators.
- Round-robin arbitration; one frame in flight at a time.
- Drives per-channel chip-select / clock / data pins (CS1/SCLK1/SDO1, CS2/SCLK2/SDO2) so board pinout is unchanged.
- Clocked from the PLL output clock.

Parameters:
- DATA_W, 16: bits per frame, MSB first.
- CLK_DIV, 4: CLK_IN cycles per SCLK half-period. Legal range ≥1.
- CS_SETUP, 2: cycles CS low before the first SCLK rising edge. Legal range ≥1.
- CS_HOLD, 2: cycles CS stays low after the last SCLK falling edge. Legal range ≥1.
- IDLE_GAP, 2: cycles CS high after a frame before the next grant. Legal range ≥0.

Ports:
- CLK_IN, in, 1: system clock (PLL output).
- RST_N, in, 1: asynchronous active-low reset.
- REQ1, in, 1: channel 1 transfer request (level).
- DATA1, in, DATA_W: channel 1 word; sampled in the ACK1 cycle.
- ACK1, out, 1: one-cycle pulse; DATA1 captured, frame granted.
- REQ2, in, 1: channel 2 transfer request (level).
- DATA2, in, DATA_W: channel 2 word.
- ACK2, out, 1: one-cycle grant/capture pulse for channel 2.
- BUSY, out, 1: high whenever state ≠ IDLE.
- CS1, out, 1: channel 1 chip select, active low.
- SCLK1, out, 1: channel 1 serial clock, idle low.
- SDO1, out, 1: channel 1 serial data.
- CS2, out, 1: channel 2 chip select, active low.
- SCLK2, out, 1: channel 2 serial clock, idle low.
- SDO2, out, 1: channel 2 serial data.

Behaviour:
- Clocking and reset
  - One clock (CLK_IN). Reset is asynchronous, active-low (RST_N).
  - All outputs are registered; no combinational paths from inputs to outputs.
- Reset values: CS1=CS2=1, SCLK1=SCLK2=0, SDO1=SDO2=0, ACK1=ACK2=0, BUSY=0, state=IDLE, last_grant=2 (so channel 1 wins the first tie).
- States: IDLE → SETUP → SHIFT → HOLD → GAP → IDLE.
  - When IDLE_GAP=0, HOLD goes directly to IDLE.
- IDLE and arbitration
  - In IDLE, with any REQn high: grant per round-robin.
    - Only one requester high: grant it.
    - Both high: grant the channel not equal to last_grant.
  - In the grant cycle:
    - ACKn=1 for exactly one cycle.
    - DATAn is loaded into the shift register.
    - last_grant is updated.
    - Next state is SETUP.
- Handshake
  - The requester holds REQn until it sees ACKn.
  - REQn still high in the next IDLE evaluation is treated as a new request.
  - REQ is never sampled outside IDLE. Dropping REQ before ACK withdraws the request without side effect.
- SETUP (CS_SETUP cycles)
  - CSn=0 for the granted channel only. SDOn = MSB. SCLKn = 0.
- SHIFT (2·DATA_W·CLK_DIV cycles)
  - SCLKn toggles every CLK_DIV cycles, starting with a rising edge. This gives DATA_W rising edges.
  - SDOn changes only on SCLK falling edges, presenting the next bit, MSB first.
  - Data is stable across each rising edge (mode 0).
  - SHIFT ends on the DATA_W-th falling edge, with SCLKn back at 0.
- HOLD (CS_HOLD cycles): CSn=0, SCLKn=0, SDOn holds the LSB.
- GAP (IDLE_GAP cycles): CSn=1, SDOn=0.
- Non-granted channel: CS=1, SCLK=0, SDO=0 at all times.
- Frame timing
  - CS-low duration = CS_SETUP + 2·DATA_W·CLK_DIV + CS_HOLD. Defaults: 132 cycles.
  - Minimum ACK-to-ACK spacing = 1 + CS-low duration + IDLE_GAP. Defaults: 135.
- Reset mid-frame: outputs return to reset values immediately. The in-flight word is discarded and no further ACK is issued for it.
- Counters: sized with clog2 of their maximum count. The bit counter wraps only via the state change, never arithmetically.

Test Plan:
- Reset, then REQ1=1 with DATA1=16'hA5C3 → expect:
  - ACK1 pulses one cycle.
  - CS1 low 132 cycles.
  - 16 SCLK1 rising edges; bits sampled on the rising edges = A5C3.
  - CS2/SCLK2/SDO2 idle throughout.
  - Next ACK no earlier than 135 cycles after ACK1.
- REQ1 and REQ2 both asserted in the same cycle, held continuously, DATA1=16'h0001, DATA2=16'h8000 → expect grant order ch1, ch2, ch1, ch2; each frame decodes to its own word.
- REQ2 only, held for 3 frames → expect 3 consecutive ch2 grants, each 135 cycles apart; ch1 never toggles.
- RST_N pulsed low at cycle 50 of a ch1 frame → expect:
  - CS1 goes 1 and SCLK1 goes 0 immediately (asynchronous).
  - No ACK occurs during reset.
  - After release, a new REQ1 gets ACK1 one cycle after sampling.
- Parameter sweep CLK_DIV=1, IDLE_GAP=0, CS_SETUP=1, CS_HOLD=1, DATA_W=8, data 8'h5A → expect CS low 1+16+1=18 cycles and ACK-to-ACK spacing 19.
- REQ1 pulsed for one cycle while a ch2 frame is BUSY → expect no ACK1 and no ch1 frame.
